// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C requester arbiter and related shared-bus blocks.
package i2c_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_WAIT = 2'd2,
      ST_RESP = 2'd3
   } state_e;

   localparam logic [6:0] SLAVE_ADDR      = 7'h50;
   localparam int         TIMEOUT_CYC_DEF = 4096;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   idx
);

   logic [IDX_W:0]   sum;
   logic [IDX_W-1:0] cand;
   logic             found;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      sum   = '0;
      cand  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         sum = {1'b0, ptr} + (IDX_W+1)'(i);
         if (sum >= (IDX_W+1)'(NUM_REQ)) begin
            sum = sum - (IDX_W+1)'(NUM_REQ);
         end
         cand = sum[IDX_W-1:0];
         if (!found && req[cand]) begin
            found     = 1'b1;
            gnt[cand] = 1'b1;
            idx       = cand;
         end
      end
   end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Shares one I2C byte driver between NUM_REQ requesters: round-robin grant,
// command latch, exec pulse, done/timeout wait and response back to the winner.
module i2c_req_arbiter
   import i2c_pkg::*;
#(
   parameter int NUM_REQ     = 2,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
   parameter int TO_W        = 12
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_REQ-1:0]      req,
   input  logic [NUM_REQ-1:0]      req_rh_wl,
   input  logic [NUM_REQ-1:0]      req_bit_ctrl,
   input  logic [16*NUM_REQ-1:0]   req_addr,
   input  logic [8*NUM_REQ-1:0]    req_wdata,
   output logic [NUM_REQ-1:0]      gnt,
   output logic [NUM_REQ-1:0]      done,
   output logic [7:0]              rdata,
   output logic                    ack_err,
   output logic                    timeout,
   output logic                    i2c_exec,
   output logic                    i2c_rh_wl,
   output logic                    bit_ctrl,
   output logic [15:0]             i2c_addr,
   output logic [7:0]              i2c_data_w,
   input  logic                    i2c_done,
   input  logic                    i2c_ack,
   input  logic [7:0]              i2c_data_r
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   state_e               state_q, state_d;
   logic [IDX_W-1:0]     ptr_q, ptr_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [TO_W-1:0]      cnt_q, cnt_d;
   logic [NUM_REQ-1:0]   gnt_q, gnt_d;
   logic [NUM_REQ-1:0]   done_q, done_d;
   logic [7:0]           rdata_q, rdata_d;
   logic                 ack_err_q, ack_err_d;
   logic                 timeout_q, timeout_d;
   logic                 exec_q, exec_d;
   logic                 rh_wl_q, rh_wl_d;
   logic                 bit_ctrl_q, bit_ctrl_d;
   logic [15:0]          addr_q, addr_d;
   logic [7:0]           data_w_q, data_w_d;

   logic [NUM_REQ-1:0]   arb_gnt;
   logic [IDX_W-1:0]     arb_idx;
   logic                 cnt_expired;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr (
      .req (req),
      .ptr (ptr_q),
      .gnt (arb_gnt),
      .idx (arb_idx)
   );

   // Last allowed WAIT cycle; a done in this same cycle still wins.
   assign cnt_expired = (cnt_q == TO_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         ptr_q      <= '0;
         idx_q      <= '0;
         cnt_q      <= '0;
         gnt_q      <= '0;
         done_q     <= '0;
         rdata_q    <= '0;
         ack_err_q  <= 1'b0;
         timeout_q  <= 1'b0;
         exec_q     <= 1'b0;
         rh_wl_q    <= 1'b0;
         bit_ctrl_q <= 1'b0;
         addr_q     <= '0;
         data_w_q   <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         gnt_q      <= gnt_d;
         done_q     <= done_d;
         rdata_q    <= rdata_d;
         ack_err_q  <= ack_err_d;
         timeout_q  <= timeout_d;
         exec_q     <= exec_d;
         rh_wl_q    <= rh_wl_d;
         bit_ctrl_q <= bit_ctrl_d;
         addr_q     <= addr_d;
         data_w_q   <= data_w_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (req != '0) state_d = ST_EXEC;
         ST_EXEC: state_d = ST_WAIT;
         ST_WAIT: if (i2c_done || cnt_expired) state_d = ST_RESP;
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      ptr_d      = ptr_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      gnt_d      = gnt_q;
      done_d     = '0;
      rdata_d    = rdata_q;
      ack_err_d  = ack_err_q;
      timeout_d  = timeout_q;
      exec_d     = 1'b0;
      rh_wl_d    = rh_wl_q;
      bit_ctrl_d = bit_ctrl_q;
      addr_d     = addr_q;
      data_w_d   = data_w_q;
      unique case (state_q)
         ST_IDLE: begin
            if (req != '0) begin
               idx_d      = arb_idx;
               gnt_d      = arb_gnt;
               exec_d     = 1'b1;
               rh_wl_d    = req_rh_wl[arb_idx];
               bit_ctrl_d = req_bit_ctrl[arb_idx];
               addr_d     = req_addr[{arb_idx, 4'b0000} +: 16];
               data_w_d   = req_wdata[{arb_idx, 3'b000} +: 8];
            end
         end
         ST_EXEC: cnt_d = '0;
         ST_WAIT: begin
            cnt_d = cnt_q + 1'b1;
            if (i2c_done) begin
               done_d    = gnt_q;
               ack_err_d = i2c_ack;
               timeout_d = 1'b0;
               if (rh_wl_q) rdata_d = i2c_data_r;
            end else if (cnt_expired) begin
               done_d    = gnt_q;
               ack_err_d = 1'b1;
               timeout_d = 1'b1;
            end
         end
         ST_RESP: begin
            gnt_d = '0;
            ptr_d = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
         end
         default: ;
      endcase
   end

   assign gnt        = gnt_q;
   assign done       = done_q;
   assign rdata      = rdata_q;
   assign ack_err    = ack_err_q;
   assign timeout    = timeout_q;
   assign i2c_exec   = exec_q;
   assign i2c_rh_wl  = rh_wl_q;
   assign bit_ctrl   = bit_ctrl_q;
   assign i2c_addr   = addr_q;
   assign i2c_data_w = data_w_q;

endmodule

// File: doc/i2c_req_arbiter.md
Name: i2c_req_arbiter

Overview:
- Sequences and shares the single I2C byte driver (one random read or write per exec) between NUM_REQ on-chip requesters.
- Round-robin grant; latches the winner's command, pulses the driver's exec, waits for driver done or timeout, then returns read data and status to the winner.
- Runs in the driver's dri_clk domain (clk is wired to dri_clk), so no CDC is needed.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- TIMEOUT_CYC, 4096, clk cycles allowed in WAIT before abort.
- TO_W, 12, timeout counter width; must satisfy 2^TO_W >= TIMEOUT_CYC.

Ports:
- clk  in  1  block clock (dri_clk).
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester request level; held until own done.
- req_rh_wl  in  NUM_REQ  per-requester 1=read, 0=write.
- req_bit_ctrl  in  NUM_REQ  per-requester 1=16-bit word address, 0=8-bit.
- req_addr  in  16*NUM_REQ  packed word addresses; requester i uses [16i+15:16i].
- req_wdata  in  8*NUM_REQ  packed write bytes.
- gnt  out  NUM_REQ  one-hot grant, high from EXEC through RESP.
- done  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- rdata  out  8  read byte; valid with done, held until next RESP.
- ack_err  out  1  slave NACK seen; valid with done.
- timeout  out  1  transaction aborted on timeout; valid with done.
- i2c_exec  out  1  one-cycle start pulse to the driver.
- i2c_rh_wl  out  1  latched command direction.
- bit_ctrl  out  1  latched address-width select.
- i2c_addr  out  16  latched word address.
- i2c_data_w  out  8  latched write byte.
- i2c_done  in  1  driver completion pulse.
- i2c_ack  in  1  driver NACK flag.
- i2c_data_r  in  8  driver read byte.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, all outputs 0, rr pointer=0, timeout counter=0. Reset mid-transaction abandons it: no done pulse, i2c_exec low.
- All outputs are registered.
- IDLE: if req!=0, choose the first set bit searching from pointer upward with wrap. Latch index and that requester's rh_wl, bit_ctrl, addr and wdata into the driver-facing outputs. Next state is EXEC.
- EXEC (exactly 1 cycle): i2c_exec=1, gnt[idx]=1, timeout counter cleared. Next state is WAIT.
- WAIT: i2c_exec=0 and the counter increments each cycle.
  - i2c_done=1: capture rdata<=i2c_data_r when the command is a read (else rdata is unchanged), ack_err<=i2c_ack, timeout<=0. Next state is RESP.
  - Otherwise, when the counter reaches TIMEOUT_CYC-1: ack_err<=1, timeout<=1, rdata unchanged. Next state is RESP.
  - i2c_done takes priority if both occur in the same cycle.
- RESP (1 cycle): done[idx]=1, gnt still held. Pointer <= idx+1 mod NUM_REQ. Next state is IDLE with gnt cleared.
- i2c_done outside WAIT is ignored.
- Latency: req sampled at cycle N gives gnt and i2c_exec at N+1. i2c_done at cycle M gives done at M+1. The earliest next grant is M+3.
- Back-to-back requests from one requester are allowed; fairness comes from pointer rotation.
- A requester dropping req mid-transaction does not abort it; done still pulses to that requester.
- Requester inputs are only sampled in IDLE. Later changes do not affect the latched command.
- Only one transaction is outstanding at a time; i2c_exec is never re-asserted before RESP completes.

Decomposition:
- Shared package i2c_pkg:
  - state encodings ST_IDLE/ST_EXEC/ST_WAIT/ST_RESP (2-bit),
  - default SLAVE_ADDR,
  - TIMEOUT_CYC default.
- Natural sub-module: rr_arbiter, a combinational round-robin picker. Inputs are req and ptr; outputs are a one-hot grant and a binary index. It is reusable by other shared-bus blocks.

Test Plan:
- Single write: req[0]=1, wr, addr=16'h0010, wdata=8'hA5, bit_ctrl=0 → i2c_exec one cycle after req with matching address/data. A driver model returns done with ack=0 → done[0] one cycle later, ack_err=0, timeout=0.
- Single read: req[1], rd, addr=16'h1234, bit_ctrl=1; driver returns data_r=8'h5A → rdata=8'h5A with done[1]; i2c_addr=16'h1234 and bit_ctrl=1 held throughout WAIT.
- Contention: req=2'b11 held continuously for 4 transactions → grants alternate 0,1,0,1; each gnt is one-hot; i2c_exec is never asserted while WAIT is active.
- NACK: driver returns done with i2c_ack=1 → ack_err=1, timeout=0, done pulses once.
- Timeout: driver never returns done → exactly TIMEOUT_CYC cycles after EXEC, done pulses with timeout=1 and ack_err=1, and the next request is served normally.
- Reset mid-WAIT: assert rst → next cycle all outputs are 0, no done pulse, and the first grant after release goes to requester 0.
